fp_mult_drain: RTL and testbench
================================

# fp_mult_drain

Result drain stage directly downstream of `fp_mult_top`. Tracks which multiplier pipeline slots carry real operations and captures the matching `z`/`status` when they emerge. Buffers the captured results in a small FIFO with a valid/ready output. Keeps sticky IEEE exception flags. Exposes an issue-credit signal (`in_ready`) to the upstream operand source, because the multiplier pipeline cannot stall.

## Interface
- `LATENCY`, 3: cycles from operands applied to `fp_mult_top` until its `z`/`status` are valid; must match the multiplier.
- `DEPTH`, 4: number of FIFO entries; power of two, at least 2.
- `clk  in  1`: single clock; all state is updated on the rising edge.
- `rst  in  1`: reset, asynchronous and active-low.
- `in_valid  in  1`: operands are presented to `fp_mult_top` this cycle.
- `in_ready  out  1`: an issue is permitted this cycle.
- `z_in  in  32`: `fp_mult_top.z`.
- `status_in  in  8`: `fp_mult_top.status`. Bit 0 = zero, 1 = inf, 2 = nan, 3 = tiny, 4 = huge, bits 7:5 are reserved and passed through.
- `out_valid  out  1`: FIFO head is valid.
- `out_ready  in  1`: consumer accepts the head.
- `out_z  out  32`: head result.
- `out_status  out  8`: head status.
- `sticky  out  5`: OR of `status_in[4:0]` over all captured results since the last clear.
- `clr_sticky  in  1`: single-cycle clear pulse for `sticky`.
- `count  out  $clog2(DEPTH+1)`: current FIFO occupancy.
- `issue_err  out  1`: sticky flag; set when `in_valid=1` while `in_ready=0`. Cleared only by reset.

## Operation
- **Issue tracking.** `vpipe[LATENCY-1:0]` is a shift register.
  - Each edge, `vpipe[0]` loads `in_valid & in_ready` and `vpipe[k]` loads `vpipe[k-1]`.
  - `inflight` = popcount of `vpipe`.
- **Capture.** When `vpipe[LATENCY-1]=1`, the block writes `{z_in, status_in}` into the FIFO at the next edge.
  - Slots with `vpipe[LATENCY-1]=0` are ignored, regardless of `z_in`.
- **Credit.** `in_ready = (count + inflight) < DEPTH`, computed combinationally from registers only.
  - A same-cycle pop is deliberately not credited, so there is no `out_ready`→`in_ready` path.
  - With this rule the FIFO can never overflow, so no full-drop logic is needed.
- **Issue violation.** If `in_valid=1` while `in_ready=0`, the issue is not tracked (its result is never captured) and `issue_err` is set.
- **FIFO.** First-word-fall-through, with `out_valid = (count != 0)` and `out_z`/`out_status` taken from the entry at the read pointer.
  - Pop on `out_valid & out_ready`.
  - Simultaneous capture and pop: both happen and `count` is unchanged.
  - Pop when empty: no effect.
  - Pointers wrap modulo `DEPTH`.
- **Sticky flags.**
  - On a capture edge: `sticky <= sticky | status_in[4:0]`.
  - On `clr_sticky` alone: `sticky <= 0`.
  - `clr_sticky` and capture on the same edge: `sticky <= status_in[4:0]`, so the new event is never lost.
  - The round mode is not seen by this block; it simply stores `z` bit-exact.

## Timing
- Reset values (asynchronous assertion): `vpipe`, pointers, `count`, `sticky` and `issue_err` all 0; FIFO storage 0. Consequently `out_valid=0`, `out_z=0`, `out_status=0`, `in_ready=1`.
- Latency for an issue accepted at edge `t`:
  - result captured at edge `t+LATENCY`;
  - `out_valid=1` during cycle `t+LATENCY+1` if the FIFO was empty.
- Throughput: one result per cycle, provided `out_ready` is held at 1.
- Reset mid-operation: all in-flight and buffered results are discarded. After release, stale `z_in` values still in the multiplier are never captured.

## Structure
- Shared package (alongside `round_defs.sv`): status bit index constants `ST_ZERO=0`, `ST_INF=1`, `ST_NAN=2`, `ST_TINY=3`, `ST_HUGE=4`, and a `fp_result_t` struct `{logic [31:0] z; logic [7:0] status;}`.
- One sub-module, `fp_result_fifo`: a parameterised synchronous FWFT FIFO of `fp_result_t` with a `count` output.
- The top level holds `vpipe`, the credit logic, the sticky logic and `issue_err`.

## Test plan
- Issue `a=0x40400000`, `b=0x40000000` (round mode 0) with `out_ready=1` → `out_valid` in cycle t+4, `out_z=0x40C00000`, `out_status[4:0]=0`, `sticky=0`.
- Issue `0x7F800000*0x3F800000`, then `0x7FC00000*0x3F800000` → out_z `0x7F800000` then `0x7FC00000`; `sticky=5'b00110`.
- Hold `out_ready=0` and issue back-to-back → `in_ready` drops after the 4th issue. A 5th `in_valid` sets `issue_err` and produces no 5th entry. Then `out_ready=1` → exactly 4 pops in issue order.
- Stream 20 issues with `out_ready` toggling every cycle → order preserved, `count` ≤ 4, no lost or duplicated results.
- Assert `clr_sticky` on the same edge as capturing an inf result, with prior `sticky=5'b00100` → `sticky=5'b00010`.
- Assert `rst=0` with 2 in flight and 1 buffered → immediately `out_valid=0`, `count=0`, `in_ready=1`. After release, no stale capture within `LATENCY+2` cycles.

Source files
------------

// File: rtl/fp_mult_drain_pkg.sv
// Shared definitions for the multiplier result drain.
// Status bit positions as produced by fp_mult_top, and the result record
// stored in the drain FIFO.
package fp_mult_drain_pkg;

  localparam int ST_ZERO = 0;
  localparam int ST_INF  = 1;
  localparam int ST_NAN  = 2;
  localparam int ST_TINY = 3;
  localparam int ST_HUGE = 4;

  typedef struct packed {
    logic [31:0] z;
    logic [7:0]  status;
  } fp_result_t;

endpackage

// File: rtl/fp_result_fifo.sv
// Synchronous first-word-fall-through FIFO of fp_result_t.
// Ports:
//   clk, rst     clock and asynchronous active-low reset
//   wr_en        write wr_data this edge (caller guarantees space)
//   wr_data      entry to write
//   rd_en        consumer accepts the head; ignored when empty
//   rd_data      head entry (entry at the read pointer)
//   valid        FIFO not empty
//   count        current occupancy
module fp_result_fifo
  import fp_mult_drain_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  fp_result_t      wr_data,
  input  logic            rd_en,
  output fp_result_t      rd_data,
  output logic            valid,
  output logic [CW-1:0]   count
);

  localparam int AW = $clog2(DEPTH);

  fp_result_t     mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           pop;

  assign valid   = (count != '0);
  assign pop     = rd_en & valid;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr_en && !pop)      count <= count + CW'(1);
      else if (!wr_en && pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/fp_mult_drain.sv
// Result drain stage behind fp_mult_top. Tracks which multiplier slots
// carry real operations, captures their z/status into a FWFT FIFO, keeps
// sticky exception flags and hands issue credit back upstream, since the
// multiplier pipeline cannot stall.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   in_valid / in_ready   operand issue handshake (in_ready is credit)
//   z_in, status_in       multiplier outputs, valid LATENCY cycles after issue
//   out_valid/out_ready   result handshake; out_z/out_status head of FIFO
//   sticky                OR of status_in[4:0] over captures since clr_sticky
//   clr_sticky            one-cycle clear of sticky
//   count                 FIFO occupancy
//   issue_err             set on issue without credit; cleared by reset only
module fp_mult_drain
  import fp_mult_drain_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                z_in,
  input  logic [7:0]                 status_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_z,
  output logic [7:0]                 out_status,
  output logic [4:0]                 sticky,
  input  logic                       clr_sticky,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       issue_err
);

  localparam int IW = $clog2(LATENCY + 1);

  logic [LATENCY-1:0] vpipe;
  logic [IW-1:0]      inflight;
  logic               accept;
  logic               capture;
  fp_result_t         wr_data;
  fp_result_t         head;

  always_comb begin
    inflight = '0;
    for (int k = 0; k < LATENCY; k++) inflight = inflight + IW'(vpipe[k]);
  end

  // Credit ignores a same-cycle pop so out_ready never reaches in_ready;
  // with every in-flight slot reserved the FIFO cannot overflow.
  assign in_ready = (32'(count) + 32'(inflight)) < 32'(DEPTH);
  assign accept   = in_valid & in_ready;
  assign capture  = vpipe[LATENCY-1];
  assign wr_data  = '{z: z_in, status: status_in};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vpipe     <= '0;
      sticky    <= '0;
      issue_err <= 1'b0;
    end else begin
      vpipe <= (vpipe << 1) | LATENCY'(accept);
      // A capture coinciding with a clear keeps the new event.
      if (capture && clr_sticky) sticky <= status_in[ST_HUGE:ST_ZERO];
      else if (capture)          sticky <= sticky | status_in[ST_HUGE:ST_ZERO];
      else if (clr_sticky)       sticky <= '0;
      if (in_valid && !in_ready) issue_err <= 1'b1;
    end
  end

  fp_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (capture),
    .wr_data (wr_data),
    .rd_en   (out_ready),
    .rd_data (head),
    .valid   (out_valid),
    .count   (count)
  );

  assign out_z      = head.z;
  assign out_status = head.status;

endmodule

// File: tb/tb_fp_mult_drain.sv
module tb_fp_mult_drain;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] z_in;
  logic [7:0]  status_in;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_z;
  logic [7:0]  out_status;
  logic [4:0]  sticky;
  logic        clr_sticky = 1'b0;
  logic [2:0]  count;
  logic        issue_err;

  int total = 0;
  int bad   = 0;

  // Multiplier stand-in: the value presented with in_valid appears on
  // z_in/status_in three cycles later; idle slots carry junk.
  localparam logic [39:0] JUNK = {32'hDEADBEEF, 8'h1F};
  logic [31:0] mz = '0;
  logic [7:0]  ms = '0;
  logic [39:0] d0 = JUNK, d1 = JUNK, d2 = JUNK;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d0 <= in_valid ? {mz, ms} : JUNK;
    d1 <= d0;
    d2 <= d1;
  end
  assign z_in      = d2[39:8];
  assign status_in = d2[7:0];

  fp_mult_drain #(.LATENCY(3), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .z_in       (z_in),
    .status_in  (status_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .out_status (out_status),
    .sticky     (sticky),
    .clr_sticky (clr_sticky),
    .count      (count),
    .issue_err  (issue_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] z, input logic [7:0] st);
    in_valid = 1'b1;
    mz = z;
    ms = st;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] q[$];
  int issued;
  int cyc;

  initial begin
    // reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_z", out_z, 0);
    chk("rst_out_status", out_status, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_sticky", sticky, 0);
    chk("rst_issue_err", issue_err, 0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // single normal product: 3.0 * 2.0 = 6.0
    issue(32'h40C00000, 8'h00);
    step();
    step();
    chk("t1_not_yet", out_valid, 0);
    step();
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_z", out_z, 32'h40C00000);
    chk("t1_out_status", out_status[4:0], 0);
    chk("t1_sticky", sticky, 0);
    step();
    chk("t1_popped", out_valid, 0);

    // inf then nan, held in FIFO
    out_ready = 1'b0;
    issue(32'h7F800000, 8'h02);
    issue(32'h7FC00000, 8'h04);
    step(); step(); step();
    chk("t2_count", count, 2);
    chk("t2_head_z", out_z, 32'h7F800000);
    chk("t2_sticky", sticky, 5'b00110);
    out_ready = 1'b1;
    step();
    chk("t2_second_z", out_z, 32'h7FC00000);
    chk("t2_second_st", out_status, 8'h04);
    step();
    chk("t2_empty", out_valid, 0);

    // clear alone, then clear on the same edge as an inf capture
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("t5_clr", sticky, 0);
    issue(32'h7FC00000, 8'h04);
    step(); step(); step();
    chk("t5_prior", sticky, 5'b00100);
    issue(32'h7F800000, 8'h02);
    step(); step();
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    chk("t5_clr_capture", sticky, 5'b00010);
    step(); step();
    chk("t5_drained", count, 0);

    // credit exhaustion with consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_in_ready_%0d", i), in_ready, (i < 4) ? 1 : 0);
      in_valid = 1'b1;
      mz = 32'h10000001 + 32'(i);
      ms = {3'(i), 5'b0};
      step();
    end
    in_valid = 1'b0;
    chk("t3_issue_err", issue_err, 1);
    step(); step(); step(); step();
    chk("t3_count_full", count, 4);
    chk("t3_in_ready_full", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_valid_%0d", i), out_valid, 1);
      chk($sformatf("t3_z_%0d", i), out_z, 32'h10000001 + 32'(i));
      chk($sformatf("t3_st_%0d", i), out_status, {3'(i), 5'b0});
      step();
    end
    chk("t3_no_fifth", out_valid, 0);
    chk("t3_count_end", count, 0);

    // streaming with toggling consumer
    issued = 0;
    cyc = 0;
    while ((issued < 20 || q.size() != 0) && cyc < 300) begin
      out_ready = cyc[0];
      in_valid = 1'b0;
      if (issued < 20 && in_ready) begin
        in_valid = 1'b1;
        mz = 32'h3F000000 + 32'(issued);
        ms = 8'h00;
        q.push_back(mz);
        issued++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("t4_spurious", out_z, 32'hFFFFFFFF);
        else chk("t4_order", out_z, q.pop_front());
      end
      chk("t4_count_le4", (count <= 4) ? 1 : 0, 1);
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("t4_timeout", (cyc < 300) ? 1 : 0, 1);
    chk("t4_issued", issued, 20);
    step(); step(); step(); step();
    chk("t4_no_extra", out_valid, 0);

    // reset with 1 buffered and 2 in flight
    out_ready = 1'b0;
    issue(32'hAAAA0001, 8'h01);
    step(); step();
    issue(32'hAAAA0002, 8'h01);
    issue(32'hAAAA0003, 8'h01);
    chk("t6_pre_count", count, 1);
    rst = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    chk("t6_rst_issue_err", issue_err, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("t6_stale_%0d", i), {out_valid, count}, 0);
    end
    chk("t6_sticky", sticky, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
